sdes_job_arbiter: RTL and testbench
===================================

# sdes_job_arbiter

Sequencer and arbiter that shares one S-DES datapath (keygen plus encryption/decryption, combinational or pipelined with fixed latency) between two requesters. It owns the 10-bit key register and schedules key updates between jobs. It grants encrypt/decrypt jobs round-robin, waits the fixed core latency, and returns each 8-bit result to the requester that issued it. It sits between the board-level front end (switch/button FSM or a future UART front end) and the shared `sdes_*` cores.

## Interface

**Parameters**
- `CORE_LAT`, default 2: cycles from `core_data`/`core_mode` stable to `core_result` valid. Legal range 1..15.

**Ports**
- `CLOCK_50`  in  1  sole clock; all state changes on its rising edge.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `key_wr`  in  1  key write strobe; one cycle.
- `key_in`  in  10  new 10-bit S-DES key, sampled when `key_wr`=1.
- `reqN_valid`  in  1  (N=0,1) requester N presents a job.
- `reqN_mode`  in  1  0 = encrypt, 1 = decrypt.
- `reqN_data`  in  8  plaintext or ciphertext.
- `reqN_ready`  out  1  job accepted this cycle when `reqN_valid`=1.
- `rspN_valid`  out  1  result available for requester N.
- `rspN_data`  out  8  result byte.
- `rspN_ready`  in  1  requester N consumes the result.
- `core_key`  out  10  key driven to the keygen.
- `core_mode`  out  1  selects the encryption or decryption result path.
- `core_data`  out  8  job byte to the core.
- `core_result`  in  8  core output, already muxed by `core_mode`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `key_loaded`  out  1  at least one key has been applied since reset.

## Operation

**Reset values.** All registers clear, state = IDLE, round-robin pointer = 1, so port 0 wins first.
- `core_key`, `core_data`, `core_mode` reset to 0.
- `rspN_valid`, `rspN_data`, `reqN_ready`, `busy`, `key_loaded` reset to 0.
- The pending-key flag resets to 0.

**Key path.**
- `key_wr` is accepted in any state into a pending shadow register and sets the pending flag. A newer `key_wr` overwrites the older pending value.
- The key is applied to `core_key` only in IDLE. Applying it clears the pending flag and sets `key_loaded`=1.
- A key-apply cycle grants no job. Key updates therefore never change `core_key` while a job is in flight.

**States.** The FSM has three states: IDLE, WAIT and RESP.
- **IDLE, key pending:** apply the key and remain in IDLE.
- **IDLE, no key pending, `key_loaded`=1, any `reqN_valid`=1:** grant one requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the port other than the pointer value is granted.
  - `reqN_ready`=1 (combinational) for the granted port only.
  - On the handshake, latch `core_data`/`core_mode` and the granted id, update the pointer to the granted id, load the wait counter with `CORE_LAT`, and go to WAIT.
- **IDLE, `key_loaded`=0:** both `reqN_ready` stay 0.
- **WAIT:** the counter decrements each cycle. When it reaches 1, capture `core_result` into `rspN_data` of the granted port, set `rspN_valid`, and go to RESP.
- **RESP:** hold `rspN_valid`/`rspN_data` until `rspN_ready`=1, then clear `rspN_valid` and return to IDLE.

**Further rules.**
- `reqN_ready` is 0 outside IDLE.
- The non-granted port's `rsp` outputs stay 0/unchanged.
- `core_data`/`core_mode` are held stable from accept until the next accept.
- A requester may drop `reqN_valid` before it is granted; no job is created.
- `RESET_N` low in any state aborts the in-flight job: no response is produced and the pending key is lost.

## Timing

- Accept handshake in cycle 0 (IDLE). WAIT occupies cycles 1..`CORE_LAT`.
- `core_result` is sampled at the end of cycle `CORE_LAT`. `rspN_valid`=1 from cycle `CORE_LAT`+1.
- A response consumed in cycle k gives IDLE in cycle k+1, where the next grant may complete.
- Best-case throughput is one job per `CORE_LAT`+2 cycles.
- If `key_wr` coincides with a grant cycle in IDLE, the grant proceeds with the old key. The new key applies in the next IDLE cycle, before the next grant.
- `key_wr` in WAIT or RESP is deferred; it costs exactly one extra IDLE cycle.

## Test plan

1. **Reset and key load.** Deassert `RESET_N`; both requesters valid; no `key_wr`.
   - Required: `reqN_ready` stays 0 and `key_loaded`=0.
   - Then `key_wr` with `key_in`=10'b1010000010: `core_key`=10'b1010000010 and `key_loaded`=1 one cycle later.
2. **Single encrypt, `CORE_LAT`=2.** Key 10'b1010000010; `req0` encrypt, data 8'b10010111.
   - Required: `req0_ready` in cycle 0; `rsp0_valid` rises in cycle 3 with `rsp0_data`=8'b00111000; held until `rsp0_ready`.
3. **Decrypt round trip.** `req1` decrypt, data 8'b00111000, same key.
   - Required: `rsp1_data`=8'b10010111; `rsp0_valid` stays 0 throughout.
4. **Round-robin fairness.** Both requesters valid continuously with distinct data.
   - Required: grants alternate 0,1,0,1 after reset; each response is routed to its issuer; `busy` drops for exactly one cycle between jobs when each `rspN_ready` is tied high.
5. **Deferred key.** Raise `key_wr` with 10'b0000011111 during WAIT, then write 10'b1111100000 during RESP.
   - Required: `core_key` unchanged until the following IDLE cycle, then 10'b1111100000; no grant in that cycle; the next job uses the new key.
6. **Reset mid-operation.** Assert `RESET_N`=0 in WAIT cycle 1.
   - Required: all outputs return to reset values asynchronously.
   - After release: no stale `rspN_valid`, and requests remain blocked until a new `key_wr`.

Source files
------------

// File: rtl/sdes_job_arbiter.sv
// sdes_job_arbiter: shares one S-DES core between two requesters,
// grants jobs round-robin and applies key updates only between jobs.
module sdes_job_arbiter #(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_wr,
    input  logic [9:0] key_in,
    input  logic       req0_valid,
    input  logic       req0_mode,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_mode,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    input  logic       rsp1_ready,
    output logic [9:0] core_key,
    output logic       core_mode,
    output logic [7:0] core_data,
    input  logic [7:0] core_result,
    output logic       busy,
    output logic       key_loaded
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT = 4'(CORE_LAT);

    state_t     state_q;
    logic       ptr_q;
    logic       gid_q;
    logic [3:0] cnt_q;
    logic       pend_q;
    logic [9:0] pend_key_q;
    logic [9:0] key_q;
    logic [7:0] data_q;
    logic       mode_q;
    logic       rsp0_v_q;
    logic       rsp1_v_q;
    logic [7:0] rsp0_d_q;
    logic [7:0] rsp1_d_q;
    logic       busy_q;
    logic       loaded_q;

    logic       can_grant_d;
    logic       gnt0_d;
    logic       gnt1_d;
    logic       rsp_take_d;

    // ptr_q holds the last granted port; on contention the other one wins
    always_comb begin
        can_grant_d = (state_q == IDLE) && !pend_q && loaded_q;
        gnt0_d      = can_grant_d && req0_valid && (!req1_valid || ptr_q);
        gnt1_d      = can_grant_d && req1_valid && (!req0_valid || !ptr_q);
        rsp_take_d  = gid_q ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b1;
            gid_q      <= 1'b0;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            pend_key_q <= 10'd0;
            key_q      <= 10'd0;
            data_q     <= 8'd0;
            mode_q     <= 1'b0;
            rsp0_v_q   <= 1'b0;
            rsp1_v_q   <= 1'b0;
            rsp0_d_q   <= 8'd0;
            rsp1_d_q   <= 8'd0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        key_q    <= pend_key_q;
                        loaded_q <= 1'b1;
                        pend_q   <= 1'b0;
                    end else if (gnt0_d || gnt1_d) begin
                        data_q  <= gnt1_d ? req1_data : req0_data;
                        mode_q  <= gnt1_d ? req1_mode : req0_mode;
                        gid_q   <= gnt1_d;
                        ptr_q   <= gnt1_d;
                        cnt_q   <= LAT;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        if (gid_q) begin
                            rsp1_d_q <= core_result;
                            rsp1_v_q <= 1'b1;
                        end else begin
                            rsp0_d_q <= core_result;
                            rsp0_v_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    if (rsp_take_d) begin
                        rsp0_v_q <= 1'b0;
                        rsp1_v_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // a write landing on an apply cycle survives as the next pending key
            if (key_wr) begin
                pend_key_q <= key_in;
                pend_q     <= 1'b1;
            end
        end
    end

    assign req0_ready = gnt0_d;
    assign req1_ready = gnt1_d;
    assign rsp0_valid = rsp0_v_q;
    assign rsp1_valid = rsp1_v_q;
    assign rsp0_data  = rsp0_d_q;
    assign rsp1_data  = rsp1_d_q;
    assign core_key   = key_q;
    assign core_mode  = mode_q;
    assign core_data  = data_q;
    assign busy       = busy_q;
    assign key_loaded = loaded_q;

endmodule

// File: tb/tb_sdes_job_arbiter.sv
// tb_sdes_job_arbiter: directed plan plus randomized traffic checked
// against a timestamp-based job model and a behavioural S-DES core.
module tb_sdes_job_arbiter;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_wr = 1'b0;
    logic [9:0] key_in = '0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_mode = 1'b0, req1_mode = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [9:0] core_key;
    logic       core_mode;
    logic [7:0] core_data;
    logic [7:0] core_result;
    logic       busy, key_loaded;

    always #5 clk = ~clk;

    sdes_job_arbiter #(.CORE_LAT(L)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .key_wr     (key_wr),
        .key_in     (key_in),
        .req0_valid (req0_valid),
        .req0_mode  (req0_mode),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_mode  (req1_mode),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .core_key   (core_key),
        .core_mode  (core_mode),
        .core_data  (core_data),
        .core_result(core_result),
        .busy       (busy),
        .key_loaded (key_loaded)
    );

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [3:0] fk(input logic [3:0] r, input logic [7:0] k);
        logic [7:0]  e;
        logic [31:0] t0, t1;
        logic [3:0]  s;
        int          i0, i1;
        t0 = 32'hB7D81BB1;
        t1 = 32'hC613D2E4;
        e  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        i0 = int'({e[7], e[4], e[6], e[5]});
        i1 = int'({e[3], e[0], e[2], e[1]});
        s  = {t0[i0*2 +: 2], t1[i1*2 +: 2]};
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [7:0] sdes(input logic [9:0] k, input logic [7:0] d,
                                        input logic dec);
        logic [9:0] p;
        logic [4:0] a, b;
        logic [7:0] k1, k2, ka, kb, ip, o;
        logic [3:0] l1, l2;
        p  = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
        a  = {p[8:5], p[9]};
        b  = {p[3:0], p[4]};
        k1 = p8({a, b});
        a  = {a[2:0], a[4:3]};
        b  = {b[2:0], b[4:3]};
        k2 = p8({a, b});
        ka = dec ? k2 : k1;
        kb = dec ? k1 : k2;
        ip = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
        l1 = ip[7:4] ^ fk(ip[3:0], ka);
        l2 = ip[3:0] ^ fk(l1, kb);
        o  = {l2, l1};
        return {o[4], o[7], o[5], o[3], o[1], o[6], o[0], o[2]};
    endfunction

    assign core_result = sdes(core_key, core_data, core_mode);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // job model: one job at most, timed from its accept cycle
    int         cyc = 0;
    bit         m_job;
    int         m_t0, m_port, m_ptr;
    logic [7:0] m_data, m_res;
    logic       m_mode;
    bit         m_pend, m_loaded;
    logic [9:0] m_pkey, m_key;
    int         glog[$];
    int         gcyc[$];

    task automatic model_reset();
        m_job = 0; m_pend = 0; m_loaded = 0;
        m_key = '0; m_pkey = '0; m_ptr = 1;
    endtask

    task automatic model_step();
        int g;
        bit shown;
        g = -1;
        if (!m_job && !m_pend && m_loaded) begin
            if (req0_valid && req1_valid) g = 1 - m_ptr;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        shown = m_job && (cyc >= m_t0 + L + 1);
        chk("rdy0", 32'(req0_ready), 32'(g == 0));
        chk("rdy1", 32'(req1_ready), 32'(g == 1));
        chk("busy", 32'(busy), 32'(m_job));
        chk("rv0", 32'(rsp0_valid), 32'(shown && m_port == 0));
        chk("rv1", 32'(rsp1_valid), 32'(shown && m_port == 1));
        if (shown)
            chk("rdata", 32'(m_port == 1 ? rsp1_data : rsp0_data), 32'(m_res));
        chk("ckey", 32'(core_key), 32'(m_key));
        chk("kload", 32'(key_loaded), 32'(m_loaded));
        if (m_job) begin
            chk("cdata", 32'(core_data), 32'(m_data));
            chk("cmode", 32'(core_mode), 32'(m_mode));
        end
        if (!m_job && m_pend) begin
            m_key = m_pkey; m_loaded = 1; m_pend = 0;
        end else if (g >= 0) begin
            m_job  = 1; m_t0 = cyc; m_port = g; m_ptr = g;
            m_data = g == 1 ? req1_data : req0_data;
            m_mode = g == 1 ? req1_mode : req0_mode;
            m_res  = sdes(m_key, m_data, m_mode);
            glog.push_back(g);
            gcyc.push_back(cyc);
        end else if (shown && (m_port == 1 ? rsp1_ready : rsp0_ready)) begin
            m_job = 0;
        end
        if (key_wr) begin
            m_pend = 1; m_pkey = key_in;
        end
        cyc++;
    endtask

    task automatic sync();
        @(negedge clk);
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rv0"}, 32'(rsp0_valid), 0);
        chk({tag, "_rv1"}, 32'(rsp1_valid), 0);
        chk({tag, "_rd0"}, 32'(rsp0_data), 0);
        chk({tag, "_rd1"}, 32'(rsp1_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_kl"}, 32'(key_loaded), 0);
        chk({tag, "_ckey"}, 32'(core_key), 0);
        chk({tag, "_cdat"}, 32'({core_mode, core_data}), 0);
        chk({tag, "_rdy"}, 32'({req0_ready, req1_ready}), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic load_key(input logic [9:0] k);
        key_wr = 1'b1;
        key_in = k;
        sync(); adv();
        key_wr = 1'b0;
        sync(); adv();
        sync(); adv();
    endtask

    initial begin
        bit         seen;
        logic [7:0] d3;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("init");

        // 1: no requests granted before a key exists
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            sync();
            chk("t1_rdy", 32'({req0_ready, req1_ready}), 0);
            chk("t1_kl", 32'(key_loaded), 0);
            adv();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        key_wr = 1'b1;
        key_in = 10'b1010000010;
        sync(); adv();
        key_wr = 1'b0;
        sync();
        chk("t1_kl_pend", 32'(key_loaded), 0);
        adv();
        sync();
        chk("t1_key", 32'(core_key), 32'(10'b1010000010));
        chk("t1_kl_set", 32'(key_loaded), 1);
        adv();

        // 2: single encrypt
        req0_valid = 1'b1;
        req0_mode  = 1'b0;
        req0_data  = 8'b10010111;
        sync();
        chk("t2_rdy0", 32'(req0_ready), 1);
        adv();
        req0_valid = 1'b0;
        for (int i = 1; i <= L; i++) begin
            sync();
            chk("t2_early", 32'(rsp0_valid), 0);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            sync();
            chk("t2_rv0", 32'(rsp0_valid), 1);
            chk("t2_rd0", 32'(rsp0_data), 32'(8'b00111000));
            adv();
        end
        rsp0_ready = 1'b1;
        sync(); adv();
        rsp0_ready = 1'b0;
        sync();
        chk("t2_drop", 32'(rsp0_valid), 0);
        adv();

        // 3: decrypt round trip on port 1
        req1_valid = 1'b1;
        req1_mode  = 1'b1;
        req1_data  = 8'b00111000;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            sync();
            chk("t3_rv0", 32'(rsp0_valid), 0);
            if (rsp1_valid) begin
                seen = 1;
                chk("t3_rd1", 32'(rsp1_data), 32'(8'b10010111));
            end
            adv();
            if (req1_ready === 1'b0 && busy) req1_valid = 1'b0;
        end
        req1_valid = 1'b0;
        chk("t3_seen", 32'(seen), 1);
        rsp1_ready = 1'b1;
        sync(); adv();
        rsp1_ready = 1'b0;

        // 4: round-robin with consumers always ready
        do_reset();
        load_key(10'b1010000010);
        glog.delete();
        gcyc.delete();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            req0_mode = 1'($urandom);
            req1_mode = 1'($urandom);
            sync(); adv();
        end
        chk("t4_ngrants", 32'(glog.size() >= 4), 1);
        if (glog.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk("t4_order", 32'(glog[i]), 32'(i % 2));
            chk("t4_period", 32'(gcyc[1] - gcyc[0]), 32'(L + 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) begin sync(); adv(); end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // 5: key writes during WAIT and RESP are deferred
        req0_valid = 1'b1;
        req0_mode  = 1'b0;
        req0_data  = 8'h5A;
        sync();
        chk("t5_rdy0", 32'(req0_ready), 1);
        adv();
        key_wr = 1'b1;
        key_in = 10'b0000011111;
        sync();
        chk("t5_key_w", 32'(core_key), 32'(10'b1010000010));
        adv();
        key_wr = 1'b0;
        for (int i = 2; i <= L; i++) begin sync(); adv(); end
        key_wr = 1'b1;
        key_in = 10'b1111100000;
        sync();
        chk("t5_rv0", 32'(rsp0_valid), 1);
        adv();
        key_wr = 1'b0;
        rsp0_ready = 1'b1;
        sync(); adv();
        rsp0_ready = 1'b0;
        d3 = 8'hC3;
        req0_data = d3;
        sync();
        chk("t5_key_old", 32'(core_key), 32'(10'b1010000010));
        chk("t5_nogrant", 32'(req0_ready), 0);
        adv();
        sync();
        chk("t5_key_new", 32'(core_key), 32'(10'b1111100000));
        chk("t5_grant", 32'(req0_ready), 1);
        adv();
        req0_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            sync();
            if (rsp0_valid) begin
                seen = 1;
                chk("t5_rd0", 32'(rsp0_data), 32'(sdes(10'b1111100000, d3, 1'b0)));
            end
            adv();
        end
        chk("t5_seen", 32'(seen), 1);
        rsp0_ready = 1'b1;
        sync(); adv();
        rsp0_ready = 1'b0;

        // 6: reset during WAIT aborts the job and forgets the key
        req0_valid = 1'b1;
        req0_data  = 8'($urandom);
        sync();
        chk("t6_rdy0", 32'(req0_ready), 1);
        adv();
        req0_valid = 1'b0;
        key_wr = 1'b1;
        key_in = 10'h155;
        #2 rst_n = 1'b0;
        key_wr = 1'b0;
        #1 check_reset_outputs("t6");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sync();
            chk("t6_stale", 32'({rsp0_valid, rsp1_valid}), 0);
            chk("t6_block", 32'({req0_ready, req1_ready}), 0);
            adv();
        end
        load_key(10'($urandom));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(9) < 7);
            req1_valid = ($urandom_range(9) < 7);
            req0_mode  = 1'($urandom);
            req1_mode  = 1'($urandom);
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            key_wr     = ($urandom_range(15) == 0);
            key_in     = 10'($urandom);
            sync(); adv();
        end
        key_wr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
